// File: rtl/somador.sv
// somador: registered signed adder with overflow flag; one-cycle latency.
// Define SOMADOR_SAT_EN to saturate the sum on overflow instead of wrapping.
module somador #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic             flag,
   output logic             out_valid
);
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf;
   logic [WIDTH-1:0] r_s;
   logic             r_flag;
   logic             r_out_valid;
   always_comb begin
      w_sum = a + b;
      w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
`ifdef SOMADOR_SAT_EN
      // Overflow direction follows the shared operand sign.
      w_res = w_ovf ? (a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : w_sum;
`else
      w_res = w_sum;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s         <= '0;
         r_flag      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_s    <= w_res;
            r_flag <= w_ovf;
         end
      end
   end
   assign s         = r_s;
   assign flag      = r_flag;
   assign out_valid = r_out_valid;
endmodule

// File: tb/tb_somador.sv
// tb_somador: directed checks of somador (WIDTH=8); overflow expectations follow SOMADOR_SAT_EN.
module tb_somador;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [7:0] s;
   logic       flag;
   logic       out_valid;
   int n_cmp = 0;
   int n_err = 0;

   somador #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
      .s(s), .flag(flag), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; a = 8'd5; b = 8'd5;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (s !== 8'h00) begin n_err++; $display("FAIL reset_s got=%h exp=00", s); end
      n_cmp++; if (flag !== 1'b0) begin n_err++; $display("FAIL reset_flag got=%b exp=0", flag); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (s !== 8'd10) begin n_err++; $display("FAIL first_s got=%h exp=0a", s); end
      n_cmp++; if (flag !== 1'b0) begin n_err++; $display("FAIL first_flag got=%b exp=0", flag); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got=%b exp=1", out_valid); end
   endtask

   task automatic test_no_overflow();
      logic [7:0] va [4] = '{8'hFF, 8'h7F, 8'h80, 8'h08};
      logic [7:0] vb [4] = '{8'hFE, 8'hFE, 8'h04, 8'hFC};
      logic [7:0] vs [4] = '{8'hFD, 8'h7D, 8'h84, 8'h04};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); in_valid = 1'b1; a = va[i]; b = vb[i];
         @(posedge clk); #1;
         n_cmp++; if (s !== vs[i]) begin n_err++; $display("FAIL nov_s[%0d] got=%h exp=%h", i, s, vs[i]); end
         n_cmp++; if (flag !== 1'b0) begin n_err++; $display("FAIL nov_flag[%0d] got=%b exp=0", i, flag); end
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL nov_valid[%0d] got=%b exp=1", i, out_valid); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] va [5] = '{8'h80, 8'h7F, 8'h7F, 8'h80, 8'h80};
      logic [7:0] vb [5] = '{8'hFE, 8'h01, 8'h07, 8'hFF, 8'h00};
`ifdef SOMADOR_SAT_EN
      logic [7:0] vs [5] = '{8'h80, 8'h7F, 8'h7F, 8'h80, 8'h80};
`else
      logic [7:0] vs [5] = '{8'h7E, 8'h80, 8'h86, 8'h7F, 8'h80};
`endif
      logic       vf [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); in_valid = 1'b1; a = va[i]; b = vb[i];
         @(posedge clk); #1;
         n_cmp++; if (s !== vs[i]) begin n_err++; $display("FAIL ovf_s[%0d] got=%h exp=%h", i, s, vs[i]); end
         n_cmp++; if (flag !== vf[i]) begin n_err++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", i, flag, vf[i]); end
      end
      @(negedge clk); in_valid = 1'b1; a = 8'h00; b = 8'h00;
      @(posedge clk); #1;
      n_cmp++; if (s !== 8'h00) begin n_err++; $display("FAIL zero_s got=%h exp=00", s); end
      n_cmp++; if (flag !== 1'b0) begin n_err++; $display("FAIL zero_flag got=%b exp=0", flag); end
   endtask

   task automatic test_hold();
`ifdef SOMADOR_SAT_EN
      logic [7:0] exp_s = 8'h7F;
`else
      logic [7:0] exp_s = 8'h80;
`endif
      @(negedge clk); in_valid = 1'b1; a = 8'h7F; b = 8'h01;
      @(negedge clk); in_valid = 1'b0; a = 8'h00; b = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (s !== exp_s) begin n_err++; $display("FAIL hold_s[%0d] got=%h exp=%h", i, s, exp_s); end
         n_cmp++; if (flag !== 1'b1) begin n_err++; $display("FAIL hold_flag[%0d] got=%b exp=1", i, flag); end
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_valid[%0d] got=%b exp=0", i, out_valid); end
      end
   endtask

   task automatic test_sat_mixed();
      @(negedge clk); in_valid = 1'b1; a = 8'hFF; b = 8'hFE;
      @(posedge clk); #1;
      n_cmp++; if (s !== 8'hFD) begin n_err++; $display("FAIL carry_s got=%h exp=fd", s); end
      n_cmp++; if (flag !== 1'b0) begin n_err++; $display("FAIL carry_flag got=%b exp=0", flag); end
   endtask

   task automatic test_async_reset();
      @(negedge clk); in_valid = 1'b1; a = 8'h7F; b = 8'h07;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_async_valid got=%b exp=1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (s !== 8'h00) begin n_err++; $display("FAIL async_s got=%h exp=00", s); end
      n_cmp++; if (flag !== 1'b0) begin n_err++; $display("FAIL async_flag got=%b exp=0", flag); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_valid got=%b exp=0", out_valid); end
      @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_async_valid got=%b exp=0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_no_overflow();
      test_overflow();
      test_hold();
      test_sat_mixed();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
